oflow_core_result_write_arbiter: RTL and testbench

//  Shares the single write port of the per-set result buffer among the PE_NUM PEs.

---
 rtl/oflow_core_result_write_arbiter.sv | 139 +++++++++++++
 tb/tb_oflow_core_result_write_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/oflow_core_result_write_arbiter.sv
// Round-robin arbiter that serialises per-PE {id, score} results of one registration
// set into the result buffer write port, then pulses done_set once every active PE is written.
module oflow_core_result_write_arbiter #(
    parameter int PE_NUM      = 24,
    parameter int ID_WIDTH    = 12,
    parameter int SCORE_WIDTH = 16,
    parameter int ADDR_WIDTH  = 10
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start_set,
    input  logic [PE_NUM-1:0]               active_mask,
    input  logic [ADDR_WIDTH-1:0]           set_base_addr,
    input  logic [PE_NUM-1:0]               req_i,
    input  logic [PE_NUM*ID_WIDTH-1:0]      id_i,
    input  logic [PE_NUM*SCORE_WIDTH-1:0]   score_i,
    output logic [PE_NUM-1:0]               ack_o,
    output logic                            wr_en,
    output logic [ADDR_WIDTH-1:0]           wr_addr,
    output logic [ID_WIDTH+SCORE_WIDTH-1:0] wr_data,
    output logic                            busy,
    output logic                            done_set
);

    localparam int PTR_W  = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;
    localparam int DATA_W = ID_WIDTH + SCORE_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [PE_NUM-1:0]       pending_q, pending_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic                    wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]       wr_data_q, wr_data_d;

    logic [PE_NUM-1:0]       eligible_s;
    logic [PE_NUM-1:0]       grant_onehot_s;
    logic [PTR_W-1:0]        grant_idx_s;
    logic                    grant_found_s;
    logic [PTR_W:0]          cand_s;
    logic [PTR_W:0]          sum_s;

    // Round-robin search: first eligible PE at or after rr_ptr, wrapping at PE_NUM.
    always_comb begin
        eligible_s    = req_i & pending_q;
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        sum_s         = '0;
        cand_s        = '0;
        for (int i = 0; i < PE_NUM; i++) begin
            sum_s  = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
            cand_s = (sum_s >= (PTR_W+1)'(PE_NUM)) ? (sum_s - (PTR_W+1)'(PE_NUM)) : sum_s;
            if (!grant_found_s && eligible_s[cand_s[PTR_W-1:0]]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_s[PTR_W-1:0];
            end else begin
                grant_found_s = grant_found_s;
            end
        end
        grant_onehot_s = {{(PE_NUM-1){1'b0}}, 1'b1} << grant_idx_s;
    end

    // Next-state, grant and write-port decode.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        base_d    = base_q;
        rr_ptr_d  = rr_ptr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        ack_o     = '0;
        case (state_q)
            ST_IDLE: begin
                if (start_set) begin
                    pending_d = active_mask;
                    base_d    = set_base_addr;
                    state_d   = (active_mask != '0) ? ST_COLLECT : ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (grant_found_s) begin
                    ack_o     = grant_onehot_s;
                    pending_d = pending_q & ~grant_onehot_s;
                    rr_ptr_d  = (grant_idx_s == PTR_W'(PE_NUM-1)) ? '0 : (grant_idx_s + PTR_W'(1));
                    wr_en_d   = 1'b1;
                    wr_addr_d = base_q + ADDR_WIDTH'(grant_idx_s);
                    wr_data_d = {id_i[grant_idx_s*ID_WIDTH +: ID_WIDTH],
                                 score_i[grant_idx_s*SCORE_WIDTH +: SCORE_WIDTH]};
                    state_d   = (pending_d == '0) ? ST_DONE : ST_COLLECT;
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and write-port registers; reset abandons any set in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            base_q    <= '0;
            rr_ptr_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            base_q    <= base_d;
            rr_ptr_q  <= rr_ptr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = (state_q == ST_COLLECT) || (state_q == ST_DONE);
    assign done_set = (state_q == ST_DONE);

endmodule

// File: tb/tb_oflow_core_result_write_arbiter.sv
// Directed testbench for oflow_core_result_write_arbiter: fixed stimulus steps with
// hand-computed grant order, write addresses, data and done_set timing.
module tb_oflow_core_result_write_arbiter;

    localparam int PE_NUM      = 24;
    localparam int ID_WIDTH    = 12;
    localparam int SCORE_WIDTH = 16;
    localparam int ADDR_WIDTH  = 10;

    logic                            clk = 1'b0;
    logic                            reset;
    logic                            start_set;
    logic [PE_NUM-1:0]               active_mask;
    logic [ADDR_WIDTH-1:0]           set_base_addr;
    logic [PE_NUM-1:0]               req_i;
    logic [PE_NUM*ID_WIDTH-1:0]      id_i;
    logic [PE_NUM*SCORE_WIDTH-1:0]   score_i;
    logic [PE_NUM-1:0]               ack_o;
    logic                            wr_en;
    logic [ADDR_WIDTH-1:0]           wr_addr;
    logic [ID_WIDTH+SCORE_WIDTH-1:0] wr_data;
    logic                            busy;
    logic                            done_set;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    oflow_core_result_write_arbiter #(
        .PE_NUM(PE_NUM), .ID_WIDTH(ID_WIDTH), .SCORE_WIDTH(SCORE_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .clk(clk), .reset(reset), .start_set(start_set), .active_mask(active_mask),
        .set_base_addr(set_base_addr), .req_i(req_i), .id_i(id_i), .score_i(score_i),
        .ack_o(ack_o), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done_set(done_set)
    );

    function automatic logic [27:0] exp_data(input int k);
        logic [11:0] id_v;
        logic [15:0] sc_v;
        id_v = 12'(32'h0A00 + k);
        sc_v = 16'(32'h5000 + 3 * k);
        return {id_v, sc_v};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [23:0] mask, input logic [9:0] base);
        start_set     = 1'b1;
        active_mask   = mask;
        set_base_addr = base;
        @(posedge clk); #1;
        start_set     = 1'b0;
    endtask

    // One COLLECT cycle granting PE k, then the write it produces one cycle later.
    task automatic grant(input int k, input logic [9:0] base, input logic last, input string tag);
        logic [23:0] oh;
        logic [9:0]  addr;
        oh   = 24'd1 << k;
        addr = base + 10'(k);
        #1;
        chk({tag, "_ack"}, 64'(ack_o), 64'(oh));
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        @(posedge clk); #1;
        chk({tag, "_wren"}, 64'(wr_en), 64'd1);
        chk({tag, "_addr"}, 64'(wr_addr), 64'(addr));
        chk({tag, "_data"}, 64'(wr_data), 64'(exp_data(k)));
        chk({tag, "_done"}, 64'(done_set), 64'(last));
    endtask

    task automatic idle_cycle(input string tag);
        #1;
        chk({tag, "_ack0"}, 64'(ack_o), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_wren0"}, 64'(wr_en), 64'd0);
        chk({tag, "_done0"}, 64'(done_set), 64'd0);
    endtask

    initial begin
        reset         = 1'b1;
        start_set     = 1'b0;
        active_mask   = '0;
        set_base_addr = '0;
        req_i         = 24'hFFFFFF;
        for (int k = 0; k < PE_NUM; k++) begin
            id_i[k*ID_WIDTH +: ID_WIDTH]          = 12'(32'h0A00 + k);
            score_i[k*SCORE_WIDTH +: SCORE_WIDTH] = 16'(32'h5000 + 3 * k);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", 64'(ack_o), 64'd0);
        chk("rst_wren", 64'(wr_en), 64'd0);
        chk("rst_addr", 64'(wr_addr), 64'd0);
        chk("rst_data", 64'(wr_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done_set), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Full set, in PE order from rr_ptr 0
        pulse_start(24'hFFFFFF, 10'h100);
        for (int k = 0; k < PE_NUM; k++) grant(k, 10'h100, k == PE_NUM - 1, "t1");
        @(posedge clk); #1;
        chk("t1_idle_busy", 64'(busy), 64'd0);
        chk("t1_idle_done", 64'(done_set), 64'd0);

        // Partial mask: only PEs 0-3 ever acked
        pulse_start(24'h00000F, 10'h200);
        for (int k = 0; k < 4; k++) grant(k, 10'h200, k == 3, "t2");
        @(posedge clk); #1;
        chk("t2_idle_busy", 64'(busy), 64'd0);
        chk("t2_idle_wren", 64'(wr_en), 64'd0);
        #1;
        chk("t2_idle_ack", 64'(ack_o), 64'd0);

        // Single-PE set moves rr_ptr to 5
        pulse_start(24'h000010, 10'h000);
        grant(4, 10'h000, 1'b1, "t2b");
        @(posedge clk); #1;

        // Rotated order 5..23, 0..4
        pulse_start(24'hFFFFFF, 10'h040);
        for (int j = 0; j < PE_NUM; j++) grant((5 + j) % PE_NUM, 10'h040, j == PE_NUM - 1, "t3");
        @(posedge clk); #1;

        // Sparse requests; bits outside pending never acked
        req_i = 24'h000000;
        pulse_start(24'h000084, 10'h300);
        for (int c = 0; c < 3; c++) idle_cycle("t4_pre");
        req_i = 24'h000080;
        grant(7, 10'h300, 1'b0, "t4_pe7");
        req_i = 24'h000180;
        idle_cycle("t4_mid");
        idle_cycle("t4_mid");
        req_i = 24'h000004;
        grant(2, 10'h300, 1'b1, "t4_pe2");
        req_i = 24'h000000;
        @(posedge clk); #1;

        // Address wrap, ignored start_set while busy, then empty-mask set
        req_i = 24'hFFFFFF;
        pulse_start(24'h000007, 10'h3FE);
        grant(0, 10'h3FE, 1'b0, "t5");
        start_set     = 1'b1;
        active_mask   = 24'hFFFFFF;
        set_base_addr = 10'h000;
        grant(1, 10'h3FE, 1'b0, "t5");
        start_set     = 1'b0;
        grant(2, 10'h3FE, 1'b1, "t5");
        @(posedge clk); #1;
        chk("t5_idle_busy", 64'(busy), 64'd0);
        pulse_start(24'h000000, 10'h123);
        chk("t5_empty_done", 64'(done_set), 64'd1);
        chk("t5_empty_wren", 64'(wr_en), 64'd0);
        chk("t5_empty_busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        chk("t5_empty_after", 64'(done_set), 64'd0);
        chk("t5_empty_idle", 64'(busy), 64'd0);

        // Reset after three writes of a full set (rr_ptr was 3)
        pulse_start(24'hFFFFFF, 10'h000);
        grant(3, 10'h000, 1'b0, "t6");
        grant(4, 10'h000, 1'b0, "t6");
        grant(5, 10'h000, 1'b0, "t6");
        #1;
        chk("t6_pre_ack", 64'(ack_o), 64'(24'h000040));
        reset = 1'b1;
        #1;
        chk("t6_rst_ack", 64'(ack_o), 64'd0);
        chk("t6_rst_wren", 64'(wr_en), 64'd0);
        chk("t6_rst_addr", 64'(wr_addr), 64'd0);
        chk("t6_rst_data", 64'(wr_data), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_done", 64'(done_set), 64'd0);
        repeat (2) begin
            @(posedge clk); #1;
            chk("t6_hold_done", 64'(done_set), 64'd0);
            chk("t6_hold_wren", 64'(wr_en), 64'd0);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        chk("t6_post_done", 64'(done_set), 64'd0);
        pulse_start(24'hFFFFFF, 10'h080);
        for (int k = 0; k < PE_NUM; k++) grant(k, 10'h080, k == PE_NUM - 1, "t6_restart");
        @(posedge clk); #1;
        chk("t6_end_busy", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
